// File: rtl/store_monitor_pkg.sv
// Shared types and widths for the CPU store monitor and its FIFO.
package store_monitor_pkg;

    localparam int STORE_CNT_W = 16;
    localparam int DROP_CNT_W  = 8;
    // Widest address/data the FIFO element can carry; narrower N is zero-extended.
    localparam int MAX_W       = 64;

    typedef struct packed {
        logic [MAX_W-1:0] addr;
        logic [MAX_W-1:0] data;
    } store_t;

    typedef enum logic {
        ARMED   = 1'b0,
        MATCHED = 1'b1
    } match_state_t;

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO of captured stores; DEPTH must be a power of two so pointers wrap naturally.
module store_fifo
    import store_monitor_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = store_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     wr_item,
    output T     rd_item,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A push into a full FIFO is allowed only when a pop frees the slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_item;
    end

    assign rd_item = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/store_monitor.sv
// Captures CPU stores into a FIFO, flags a target store, and counts accepted/dropped stores.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int             N          = 32,
    parameter int             DEPTH      = 8,
    parameter logic [N-1:0]   MATCH_ADDR = 32'd84,
    parameter logic [N-1:0]   MATCH_DATA = 32'h96
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [N-1:0]           dataadr,
    input  logic [N-1:0]           writedata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_addr,
    output logic [N-1:0]           out_data,
    output logic                   match,
    output logic                   overflow,
    output logic [STORE_CNT_W-1:0] store_count,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic                   dbg_match_state
);

    // Output handshake: the head transfers on a posedge with out_valid=1 and out_ready=1;
    // out_valid never depends on out_ready, and the head holds while out_ready=0.

    logic         store_v;
    logic         pop;
    logic         push;
    logic         drop;
    logic         hit;
    logic         full;
    logic         empty;
    store_t       wr_item;
    store_t       rd_item;
    match_state_t state_q;
    match_state_t state_d;

    // An unknown strobe must not create a store.
    assign store_v   = (memwrite === 1'b1);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = store_v && (!full || pop);
    assign drop      = store_v && full && !pop;
    assign hit       = store_v && (dataadr == MATCH_ADDR) && (writedata == MATCH_DATA);

    always_comb begin
        wr_item                = '0;
        wr_item.addr[N-1:0]    = dataadr;
        wr_item.data[N-1:0]    = writedata;
    end

    store_fifo #(
        .DEPTH (DEPTH),
        .T     (store_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_item (wr_item),
        .rd_item (rd_item),
        .full    (full),
        .empty   (empty)
    );

    assign out_addr = empty ? '0 : rd_item.addr[N-1:0];
    assign out_data = empty ? '0 : rd_item.data[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push && (store_count != '1)) store_count <= store_count + 1'b1;
            if (drop && (drop_count != '1))  drop_count  <= drop_count + 1'b1;
            if (drop)                        overflow    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARMED;
        else        state_q <= state_d;
    end

    // A hit counts even when the store itself is dropped; MATCHED holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED:   if (hit) state_d = MATCHED;
            MATCHED: state_d = MATCHED;
            default: state_d = ARMED;
        endcase
    end

    assign match           = (state_q == MATCHED);
    assign dbg_match_state = state_q;

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: queue-based reference model with a decoupled head/flag monitor.
module tb_store_monitor;

    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int W     = 2 * N;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        memwrite  = 1'b0;
    logic        out_ready = 1'b0;
    logic [N-1:0] dataadr   = '0;
    logic [N-1:0] writedata = '0;
    logic [N-1:0] out_addr;
    logic [N-1:0] out_data;
    logic        out_valid;
    logic        match;
    logic        overflow;
    logic        dbg_match_state;
    logic [15:0] store_count;
    logic [7:0]  drop_count;

    store_monitor dut (
        .clk             (clk),
        .reset           (reset),
        .memwrite        (memwrite),
        .dataadr         (dataadr),
        .writedata       (writedata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .match           (match),
        .overflow        (overflow),
        .store_count     (store_count),
        .drop_count      (drop_count),
        .dbg_match_state (dbg_match_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           m_store_cnt = 0;
    int           m_drop_cnt  = 0;
    bit           m_overflow  = 1'b0;
    bit           m_match     = 1'b0;
    bit           pend_store  = 1'b0;
    bit           pend_accept = 1'b0;
    logic [W-1:0] pend_item   = '0;
    bit           mon_en      = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit the store sampled on the edge that just passed.
    function automatic void apply_pending();
        if (pend_store) begin
            if (pend_item == {32'd84, 32'h96}) m_match = 1'b1;
            if (pend_accept) begin
                exp_q.push_back(pend_item);
                if (m_store_cnt < 65535) m_store_cnt++;
            end else begin
                m_overflow = 1'b1;
                if (m_drop_cnt < 255) m_drop_cnt++;
            end
        end
        pend_store = 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic mw, input logic [N-1:0] a, input logic [N-1:0] d,
                         input logic rdy);
        @(posedge clk);
        #1 apply_pending();
        #1;
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        out_ready = rdy;
        pend_store  = (memwrite === 1'b1);
        pend_accept = pend_store &&
                      ((exp_q.size() < DEPTH) || (rdy && exp_q.size() > 0));
        pend_item   = {a, d};
    endtask

    task automatic async_reset(input int hold_cycles);
        @(posedge clk);
        #1 apply_pending();
        #2;
        reset     = 1'b0;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid",   64'(out_valid),   '0);
        check("rst_out_addr",    64'(out_addr),    '0);
        check("rst_out_data",    64'(out_data),    '0);
        check("rst_match",       64'(match),       '0);
        check("rst_overflow",    64'(overflow),    '0);
        check("rst_store_count", 64'(store_count), '0);
        check("rst_drop_count",  64'(drop_count),  '0);
        exp_q.delete();
        m_store_cnt = 0;
        m_drop_cnt  = 0;
        m_overflow  = 1'b0;
        m_match     = 1'b0;
        pend_store  = 1'b0;
        repeat (hold_cycles) @(posedge clk);
        #2 reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset && mon_en) begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && exp_q.size() > 0) begin
                    check("head", {out_addr, out_data}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
                check("match",       64'(match),           64'(m_match));
                check("dbg_state",   64'(dbg_match_state), 64'(m_match));
                check("overflow",    64'(overflow),        64'(m_overflow));
                check("store_count", 64'(store_count),     64'(m_store_cnt));
                check("drop_count",  64'(drop_count),      64'(m_drop_cnt));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] a;
        logic [N-1:0] d;
        logic         mw;
        int           r;

        // reset held two cycles from time zero
        async_reset(2);

        // near-miss stores leave match clear
        cycle(1'b1, 32'd84, 32'h95, 1'b0);
        cycle(1'b1, 32'd80, 32'h96, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        drain(3);

        // single target store
        async_reset(1);
        cycle(1'b1, 32'd84, 32'h96, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        drain(2);

        // overfill by two, then drain in order
        async_reset(1);
        for (int i = 0; i < 10; i++) cycle(1'b1, N'(i), $urandom, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        drain(10);

        // full FIFO with simultaneous store and pop
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, N'(100 + i), $urandom, 1'b0);
        cycle(1'b1, 32'hAA, 32'h1234, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);
        drain(DEPTH + 1);

        // reset mid-cycle with five queued entries
        for (int i = 0; i < 5; i++) cycle(1'b1, N'(200 + i), $urandom, 1'b0);
        async_reset(1);
        cycle(1'b1, 32'h55, 32'h66, 1'b0);
        cycle(1'b1, 32'h56, 32'h67, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        drain(3);

        // drop counter saturation
        async_reset(1);
        for (int i = 0; i < 270; i++) cycle(1'b1, N'($urandom_range(300, 900)), $urandom, 1'b0);
        drain(DEPTH + 1);

        // randomized traffic including unknown strobes
        async_reset(1);
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 9);
            mw = (r == 0) ? 1'bx : (r < 6) ? 1'b1 : 1'b0;
            case ($urandom_range(0, 3))
                0:       a = 32'd84;
                1:       a = 32'd80;
                default: a = N'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
                0:       d = 32'h96;
                1:       d = 32'h95;
                default: d = $urandom;
            endcase
            cycle(mw, a, d, 1'($urandom_range(0, 1)));
        end
        drain(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 The block SHALL have a single clock and a reset that is asynchronous and active-low; the ports SHALL be named clk and reset.
REQ-002 Parameter N SHALL default to 32 and sets the address and data width.
REQ-003 Parameter DEPTH SHALL default to 8 and sets the FIFO entry count; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter MATCH_ADDR SHALL default to 32'd84 and sets the target store address.
REQ-005 Parameter MATCH_DATA SHALL default to 32'h96 and sets the target store data.
REQ-006 Port clk SHALL be an input, 1 bit wide, and is the system clock.
REQ-007 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-008 Port memwrite SHALL be an input, 1 bit wide, and is the CPU store strobe.
REQ-009 Port dataadr SHALL be an input, N bits wide, and is the CPU store address.
REQ-010 Port writedata SHALL be an input, N bits wide, and is the CPU store data.
REQ-011 Port out_valid SHALL be an output, 1 bit wide, and indicates that the FIFO head is valid.
REQ-012 Port out_ready SHALL be an input, 1 bit wide, and indicates that the consumer accepts the head.
REQ-013 Port out_addr SHALL be an output, N bits wide, and is the head address.
REQ-014 Port out_data SHALL be an output, N bits wide, and is the head data.
REQ-015 Port match SHALL be an output, 1 bit wide, and is a sticky flag indicating that the target store was seen.
REQ-016 Port overflow SHALL be an output, 1 bit wide, and is a sticky flag indicating that a store was dropped.
REQ-017 Port store_count SHALL be an output, 16 bits wide, and counts accepted stores (saturating).
REQ-018 Port drop_count SHALL be an output, 8 bits wide, and counts dropped stores (saturating).

Function
REQ-019 A store SHALL be sampled on each posedge clk where memwrite=1, using {dataadr, writedata} from the same edge.
REQ-020 An accepted store SHALL be visible on out_valid/out_addr/out_data one cycle after the sampling edge when the FIFO was empty; there SHALL be no combinational bypass.
REQ-021 A pop SHALL occur on a posedge where out_valid=1 and out_ready=1; out_addr and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Entries SHALL leave the FIFO in arrival order, and pointers SHALL wrap modulo DEPTH.
REQ-023 When the FIFO is full and a store arrives without a pop, the store SHALL be dropped: overflow is set, drop_count increments, and store_count is unchanged.
REQ-024 When the FIFO is full and a store arrives with a pop on the same edge, the store SHALL be accepted and there SHALL be no drop.
REQ-025 When the FIFO is empty, a store arrives, and out_ready=1 on the same edge, the store SHALL be pushed only, because out_valid=0 at that edge.
REQ-026 The match FSM SHALL have two states, ARMED and MATCHED; it SHALL move ARMED to MATCHED on a sampled store with dataadr==MATCH_ADDR and writedata==MATCH_DATA, and match SHALL be 1 exactly when the state is MATCHED.
REQ-027 A matching store SHALL set match even if that store is dropped for full.
REQ-028 MATCHED SHALL be absorbing until reset.
REQ-029 store_count SHALL saturate at 16'hFFFF, and drop_count SHALL saturate at 8'hFF.
REQ-030 When memwrite is X or Z, the cycle SHALL be treated as no store.

Reset
REQ-031 Assertion of reset (reset=0) SHALL immediately clear the FIFO pointers and occupancy, giving out_valid=0.
REQ-032 Assertion of reset SHALL immediately clear match, overflow, store_count, and drop_count, and set the FSM to ARMED.
REQ-033 During reset, out_addr and out_data SHALL read 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued stores, with no partial pop.
REQ-035 Deassertion of reset SHALL take effect at the next posedge clk, and stores sampled on that edge SHALL be accepted.

Structure
REQ-036 Package store_monitor_pkg SHALL hold the struct store_t {addr, data}, the enum match_state_t {ARMED, MATCHED}, and count width constants.
REQ-037 The FIFO SHALL be a sub-module named store_fifo, parameterised by DEPTH and element type store_t, with push/pop/full/empty ports.
REQ-038 Match detection and counters SHALL reside in store_monitor.

Verification
REQ-039 Scenario 1: reset=0 for 2 cycles, then release -> out_valid=0, match=0, overflow=0, store_count=0, and drop_count=0.
REQ-040 Scenario 2: a single store addr=84, data=32'h96 with out_ready=0 -> next cycle out_valid=1, out_addr=84, out_data=32'h96, match=1, store_count=1.
REQ-041 Scenario 3: 10 back-to-back stores addr=0..9 with out_ready=0 -> store_count=8, drop_count=2, overflow=1, then draining yields addrs 0..7 in order.
REQ-042 Scenario 4: the FIFO is full and a store plus pop occur on the same edge -> occupancy stays 8, drop_count is unchanged, and the new entry emerges last.
REQ-043 Scenario 5: a store addr=84, data=32'h95 -> match stays 0; then addr=80, data=32'h96 -> match stays 0.
REQ-044 Scenario 6: reset is asserted asynchronously mid-clock with 5 entries queued -> out_valid=0 immediately, and after release the first new store is the head.
